// File: rtl/series_job_dispatcher.sv
// Operand FIFO plus single-job issue FSM feeding the series-evaluation engine; results leave in issue order.
// Optional watchdog/abort path is built only when SERIES_DISPATCH_WATCHDOG_EN is defined.
module series_job_dispatcher #(
    parameter int DATA_W      = 16,
    parameter int RES_W       = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              eng_start,
    output logic [DATA_W-1:0] eng_x,
    input  logic              eng_ready,
    input  logic [RES_W-1:0]  eng_result,
    output logic              eng_stop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              busy,
    output logic              err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_CAPTURE, S_ABORT
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    state_t            state_reg, state_next;
    logic [DATA_W-1:0] eng_x_reg;
    logic [RES_W-1:0]  out_data_reg;
    logic              out_valid_reg;
    logic              push, pop, load_out, timeout;

    // in_ready depends only on registered count, so a same-cycle pop never opens a full FIFO
    assign in_ready = (count_reg != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (count_reg != '0 && eng_ready) state_next = S_ISSUE;
            S_ISSUE:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (timeout) state_next = S_ABORT;
                         else if (!eng_ready) state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (timeout) state_next = S_ABORT;
                         else if (eng_ready) state_next = S_CAPTURE;
            S_CAPTURE:   if (!out_valid_reg || out_ready) state_next = S_IDLE;
            S_ABORT:     if (eng_ready) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        load_out  = 1'b0;
        eng_start = 1'b0;
        busy      = (state_reg != S_IDLE) || (count_reg != '0);
        case (state_reg)
            S_IDLE:    pop = (count_reg != '0) && eng_ready;
            S_ISSUE:   eng_start = 1'b1;
            S_CAPTURE: load_out = !out_valid_reg || out_ready;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_x_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (pop) eng_x_reg <= mem[rd_ptr_reg];
            if (load_out) begin
                out_data_reg  <= eng_result;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign eng_x     = eng_x_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

`ifdef SERIES_DISPATCH_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            err_reg;
    logic            in_wait;

    assign in_wait = (state_reg == S_WAIT_BUSY) || (state_reg == S_WAIT_DONE);
    assign timeout = in_wait && (wd_cnt_reg == WD_W'(TIMEOUT_CYC));

    // counter restarts whenever a wait state is (re)entered
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (in_wait && state_next == state_reg) wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            else                                    wd_cnt_reg <= '0;
            if (timeout) err_reg <= 1'b1;
        end
    end

    assign err      = err_reg;
    assign eng_stop = (state_reg == S_ABORT);
`else
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] unused_timeout_cfg;

    assign unused_timeout_cfg = WD_W'(TIMEOUT_CYC);
    assign timeout  = 1'b0;
    assign err      = 1'b0;
    assign eng_stop = 1'b0;
`endif
endmodule

// File: tb/tb_series_job_dispatcher.sv
// Scoreboard bench for series_job_dispatcher with a behavioural engine model and randomized traffic.
module tb_series_job_dispatcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        eng_start;
    logic [15:0] eng_x;
    logic        eng_ready;
    logic [15:0] eng_result;
    logic        eng_stop;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] iss_q[$];

    logic force_busy   = 1'b0;
    logic ignore_start = 1'b0;
    int   lat_min = 2;
    int   lat_max = 6;

    logic        eng_rdy_reg;
    logic [15:0] eng_res_reg;
    int          phase;
    int          lat;

    always #5 clk = ~clk;

    series_job_dispatcher dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .eng_start(eng_start), .eng_x(eng_x), .eng_ready(eng_ready),
        .eng_result(eng_result), .eng_stop(eng_stop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    // engine transfer function, arbitrary but data dependent
    function automatic logic [15:0] eng_fn(input logic [15:0] x);
        return (x * 16'd37) ^ 16'h1234;
    endfunction

    assign eng_ready  = eng_rdy_reg && !force_busy;
    assign eng_result = eng_res_reg;

    always @(posedge clk) begin
        if (rst) begin
            eng_rdy_reg <= 1'b1;
            eng_res_reg <= '0;
            phase       <= 0;
            lat         <= 0;
        end else begin
            case (phase)
                0: if (eng_start && !ignore_start) begin
                       phase       <= 1;
                       eng_rdy_reg <= 1'b0;
                   end
                1: if (!eng_start) begin
                       phase <= 2;
                       lat   <= int'($urandom_range(lat_max, lat_min));
                   end
                default: if (lat == 0) begin
                       eng_res_reg <= eng_fn(eng_x);
                       eng_rdy_reg <= 1'b1;
                       phase       <= 0;
                   end else begin
                       lat <= lat - 1;
                   end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] x, input int budget, output logic ok);
        logic acc;
        in_valid = 1'b1;
        in_data  = x;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            acc = in_ready;
            step();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy && !out_valid) break;
            step();
        end
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_busy", busy, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    // monitor: samples at negedge, i.e. the values the coming posedge will act on
    initial begin
        logic        prev_hold = 1'b0;
        logic        prev_rst  = 1'b1;
        logic        prev_start = 1'b0;
        logic [15:0] prev_data = '0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                iss_q.delete();
            end else begin
                if (prev_hold && !prev_rst) begin
                    chk("hold_valid", out_valid, 1'b1);
                    chk("hold_data", out_data, prev_data);
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(eng_fn(in_data));
                    iss_q.push_back(in_data);
                end
                if (eng_start) begin
                    chk("start_width", prev_start, 1'b0);
                    if (iss_q.size() == 0) chk("start_unexpected", 1, 0);
                    else chk("eng_x", eng_x, iss_q.pop_front());
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("result_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e);
                        $display("result out_data=%h expected=%h", out_data, e);
                    end
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_data  = out_data;
            prev_rst   = rst;
            prev_start = eng_start && !rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        do_reset(3);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_eng_start", eng_start, 1'b0);
        chk("rst_eng_stop", eng_stop, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_eng_x", eng_x, 16'h0);
        chk("rst_out_data", out_data, 16'h0);

        // single job, fixed engine latency
        lat_min = 12; lat_max = 12;
        push(16'h0040, 4, ok);
        chk("push_single", ok, 1'b1);
        drain(200);

        // fill FIFO while engine reports busy; fifth operand must wait
        force_busy = 1'b1;
        lat_min = 3; lat_max = 8;
        step();
        for (int i = 1; i <= 4; i++) begin
            push(16'(i), 4, ok);
            chk("fill_push", ok, 1'b1);
        end
        chk("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd5;
        for (int i = 0; i < 6; i++) step();
        chk("full_held", in_ready, 1'b0);
        chk("full_busy", busy, 1'b1);
        force_busy = 1'b0;
        push(16'd5, 50, ok);
        chk("fifth_accepted", ok, 1'b1);
        drain(500);

        // back-pressure: results pile up behind out_ready=0
        out_ready = 1'b0;
        lat_min = 2; lat_max = 4;
        for (int i = 0; i < 3; i++) begin
            push(16'($urandom), 4, ok);
            chk("bp_push", ok, 1'b1);
        end
        for (int i = 0; i < 80; i++) step();
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_busy", busy, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("bp_reload", out_valid, 1'b1);
        drain(500);

        // reset while waiting for the engine with entries queued
        lat_min = 30; lat_max = 30;
        for (int i = 0; i < 4; i++) begin
            push(16'h0100 + 16'(i), 4, ok);
            chk("rstmid_push", ok, 1'b1);
        end
        for (int i = 0; i < 50 && eng_ready; i++) step();
        chk("rstmid_engine_busy", eng_ready, 1'b0);
        step(); step();
        do_reset(1);
        chk("rstmid_in_ready", in_ready, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_out_valid", out_valid, 1'b0);
        chk("rstmid_eng_start", eng_start, 1'b0);
        chk("rstmid_eng_x", eng_x, 16'h0);
        chk("rstmid_out_data", out_data, 16'h0);
        for (int i = 0; i < 40; i++) step();
        chk("rstmid_no_result", out_valid, 1'b0);

        // engine that never leaves idle
        ignore_start = 1'b1;
        push(16'h0abc, 4, ok);
        for (int i = 0; i < 300; i++) step();
        chk("stuck_out_valid", out_valid, 1'b0);
`ifdef SERIES_DISPATCH_WATCHDOG_EN
        chk("stuck_err", err, 1'b1);
        chk("stuck_busy", busy, 1'b0);
`else
        chk("stuck_err", err, 1'b0);
        chk("stuck_eng_stop", eng_stop, 1'b0);
        chk("stuck_busy", busy, 1'b1);
`endif
        ignore_start = 1'b0;
        do_reset(2);
        chk("stuck_cleared", err, 1'b0);

        // randomized traffic with random back-pressure and latency
        lat_min = 0; lat_max = 7;
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(1, 0));
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            step();
        end
        in_valid = 1'b0;
        drain(2000);
        chk("final_err", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
